branch_history_table: RTL and testbench



---
 rtl/branch_history_table_if.sv | 27 ++
 rtl/branch_history_table.sv | 75 +++++++
 tb/tb_branch_history_table.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/branch_history_table_if.sv
// Fetch/execute-side signal bundle for the branch history table.
// master = datapath (drives PC and resolved branches), slave = the table.
interface branch_history_table_if #(
  parameter int IDX_BITS = 6,
  parameter int GHR_BITS = 6
);
  localparam int GW = (GHR_BITS > 0) ? GHR_BITS : 1;

  logic [31:0]         pc_f_i;
  logic                pc_src_pred_f_o;
  logic [IDX_BITS-1:0] pred_idx_f_o;
  logic [IDX_BITS-1:0] pred_idx_e_i;
  logic                branch_op_e_i;
  logic                pc_src_res_e_i;
  logic                stall_e_i;
  logic [GW-1:0]       ghr_o;

  modport master (
    output pc_f_i, pred_idx_e_i, branch_op_e_i, pc_src_res_e_i, stall_e_i,
    input  pc_src_pred_f_o, pred_idx_f_o, ghr_o
  );

  modport slave (
    input  pc_f_i, pred_idx_e_i, branch_op_e_i, pc_src_res_e_i, stall_e_i,
    output pc_src_pred_f_o, pred_idx_f_o, ghr_o
  );
endinterface

// File: rtl/branch_history_table.sv
// Branch history table: array of 2-bit saturating counters read by fetch,
// trained by execute, with optional gshare (GHR XOR) indexing.

// One 2-bit saturating counter (11 ST, 10 WT, 01 WU, 00 SU).
module bht_ctr (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       upd,
  input  logic       taken,
  output logic [1:0] ctr
);
  // Saturating up/down on a qualified update; reset to weakly not-taken.
  always_ff @(posedge clk_i) begin
    if (reset_i)                      ctr <= 2'b01;
    else if (upd) begin
      if (taken && ctr != 2'b11)      ctr <= ctr + 2'b01;
      else if (!taken && ctr != 2'b00) ctr <= ctr - 2'b01;
    end
  end
endmodule

module branch_history_table #(
  parameter int IDX_BITS = 6,
  parameter int GHR_BITS = 6
) (
  input logic                   clk_i,
  input logic                   reset_i,
  branch_history_table_if.slave bus
);
  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int GW      = (GHR_BITS > 0) ? GHR_BITS : 1;

  logic                      upd;
  logic [ENTRIES-1:0][1:0]   ctr;
  logic [GW-1:0]             ghr;
  logic [IDX_BITS-1:0]       pc_idx;
  logic [IDX_BITS-1:0]       idx_f;
  logic                      unused_pc;

  assign upd    = bus.branch_op_e_i & ~bus.stall_e_i;
  assign pc_idx = bus.pc_f_i[IDX_BITS+1:2];
  // Byte offset and high PC bits alias freely into the table.
  assign unused_pc = ^{bus.pc_f_i[31:IDX_BITS+2], bus.pc_f_i[1:0]};

  // One counter per entry; only the execute-side index selects the writer.
  for (genvar g = 0; g < ENTRIES; g++) begin : g_ent
    bht_ctr u_ctr (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .upd     (upd && (bus.pred_idx_e_i == IDX_BITS'(g))),
      .taken   (bus.pc_src_res_e_i),
      .ctr     (ctr[g])
    );
  end

  if (GHR_BITS == 0) begin : g_no_ghr
    assign ghr   = '0;
    assign idx_f = pc_idx;
  end else begin : g_ghr
    // Global history shift on each qualified update; newest outcome in LSB.
    always_ff @(posedge clk_i) begin
      if (reset_i)  ghr <= '0;
      else if (upd) begin
        if (GHR_BITS == 1) ghr <= GW'(bus.pc_src_res_e_i);
        else               ghr <= GW'({ghr, bus.pc_src_res_e_i});
      end
    end
    assign idx_f = pc_idx ^ IDX_BITS'(ghr);
  end

  // Zero-latency read; a same-cycle write shows up only after the edge.
  assign bus.pred_idx_f_o    = idx_f;
  assign bus.pc_src_pred_f_o = ctr[idx_f][1];
  assign bus.ghr_o           = ghr;
endmodule

// File: tb/tb_branch_history_table.sv
// Bench: a pure-PC table and a gshare table driven side by side, checked
// against a counter-array model with integer saturation arithmetic.
module tb_branch_history_table;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  branch_history_table_if #(.IDX_BITS(6), .GHR_BITS(0)) if0 ();
  branch_history_table_if #(.IDX_BITS(6), .GHR_BITS(6)) if1 ();

  branch_history_table #(.IDX_BITS(6), .GHR_BITS(0)) dut0 (.clk_i(clk), .reset_i(reset), .bus(if0));
  branch_history_table #(.IDX_BITS(6), .GHR_BITS(6)) dut1 (.clk_i(clk), .reset_i(reset), .bus(if1));

  int tbl [64];
  int ghr_m;
  int errors = 0;
  int checks = 0;
  logic        obs_pred0, obs_pred1;
  logic [5:0]  obs_idx0, obs_idx1, obs_ghr1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) tbl[i] = 1;
    ghr_m = 0;
  endtask

  // One cycle: drive after negedge, check the combinational read, then
  // advance the model past the rising edge.
  task automatic step(input logic [31:0] pc, input int ie, input bit op,
                      input bit res, input bit stall, input bit rst);
    int i0, i1;
    @(negedge clk);
    reset = rst;
    if0.pc_f_i = pc; if0.pred_idx_e_i = 6'(ie); if0.branch_op_e_i = op;
    if0.pc_src_res_e_i = res; if0.stall_e_i = stall;
    if1.pc_f_i = pc; if1.pred_idx_e_i = 6'(ie); if1.branch_op_e_i = op;
    if1.pc_src_res_e_i = res; if1.stall_e_i = stall;
    #1;
    i0 = int'((pc >> 2) & 32'd63);
    i1 = i0 ^ ghr_m;
    obs_pred0 = if0.pc_src_pred_f_o; obs_idx0 = if0.pred_idx_f_o;
    obs_pred1 = if1.pc_src_pred_f_o; obs_idx1 = if1.pred_idx_f_o;
    obs_ghr1  = if1.ghr_o;
    chk("idx0",  32'(obs_idx0),  32'(i0));
    chk("pred0", 32'(obs_pred0), 32'(tbl[i0] >= 2));
    chk("idx1",  32'(obs_idx1),  32'(i1));
    chk("pred1", 32'(obs_pred1), 32'(tbl[i1] >= 2));
    chk("ghr1",  32'(obs_ghr1),  32'(ghr_m));
    chk("ghr0",  32'(if0.ghr_o), 32'd0);
    @(posedge clk);
    if (rst) model_reset();
    else if (op && !stall) begin
      if (res) tbl[ie] = (tbl[ie] == 3) ? 3 : tbl[ie] + 1;
      else     tbl[ie] = (tbl[ie] == 0) ? 0 : tbl[ie] - 1;
      ghr_m = ((ghr_m << 1) | int'(res)) & 63;
    end
  endtask

  initial begin
    logic [5:0] ghr_save;
    bit exp_t2 [8];
    exp_t2 = '{0, 1, 1, 1, 1, 1, 0, 0};

    reset = 1'b1;
    if0.pc_f_i = '0; if0.pred_idx_e_i = '0; if0.branch_op_e_i = 0; if0.pc_src_res_e_i = 0; if0.stall_e_i = 0;
    if1.pc_f_i = '0; if1.pred_idx_e_i = '0; if1.branch_op_e_i = 0; if1.pc_src_res_e_i = 0; if1.stall_e_i = 0;
    repeat (2) @(posedge clk);
    model_reset();

    // T1: every address predicts not-taken after reset
    for (int i = 0; i < 64; i++) begin
      step({$urandom_range(0, 255), 18'd0, 6'(i), 2'($urandom_range(0, 3))}, 0, 0, 0, 0, 0);
      chk("t1_pred", 32'(obs_pred0), 32'd0);
    end

    // T2: saturate entry 5 up then down (same-cycle read shows old value)
    for (int i = 0; i < 8; i++) begin
      step(32'h14, 5, 1, (i < 4), 0, 0);
      chk("t2_pred", 32'(obs_pred0), 32'(exp_t2[i]));
    end
    step(32'h14, 5, 0, 0, 0, 0);
    chk("t2_final", 32'(obs_pred0), 32'd0);

    // T3: unqualified or stalled updates change nothing
    ghr_save = obs_ghr1;
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) step($urandom, $urandom_range(0, 63), 0, i[1], $urandom_range(0, 1), 0);
      else            step($urandom, $urandom_range(0, 63), 1, i[1], 1, 0);
      chk("t3_ghr", 32'(obs_ghr1), 32'(ghr_save));
    end

    // T6: drive entry 5 to ST, then reset together with an update
    repeat (3) step(32'h14, 5, 1, 1, 0, 0);
    step(32'h14, 5, 1, 1, 0, 1);
    chk("t6_pre_pred", 32'(obs_pred0), 32'd1);
    step(32'h14, 5, 0, 0, 0, 0);
    chk("t6_pred0", 32'(obs_pred0), 32'd0);
    chk("t6_ghr",   32'(obs_ghr1),  32'd0);
    chk("t6_pred1", 32'(obs_pred1), 32'd0);

    // T4: WU->WT on idx 5 while reading idx 5
    step(32'h14, 5, 1, 1, 0, 0);
    chk("t4_same", 32'(obs_pred0), 32'd0);
    step(32'h14, 5, 0, 0, 0, 0);
    chk("t4_next", 32'(obs_pred0), 32'd1);

    // T5: gshare history T,T,N then PC 0x40
    step(32'h0, 0, 0, 0, 0, 1);
    step(32'h0, 9, 1, 1, 0, 0);
    step(32'h0, 9, 1, 1, 0, 0);
    step(32'h0, 9, 1, 0, 0, 0);
    step(32'h40, 0, 0, 0, 0, 0);
    chk("t5_ghr",  32'(obs_ghr1), 32'h06);
    chk("t5_idx1", 32'(obs_idx1), 32'd22);
    chk("t5_idx0", 32'(obs_idx0), 32'd16);

    // Random traffic, concentrated on a few entries to reach saturation
    for (int i = 0; i < 400; i++) begin
      step($urandom & 32'h0000_003c | ($urandom & 32'hffff_ff03),
           ($urandom_range(0, 1) == 1) ? $urandom_range(0, 15) : $urandom_range(0, 63),
           $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 4) == 0, $urandom_range(0, 80) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
